// File: rtl/ir_encoder.sv
// NEC infrared frame encoder: leader, 32 LSB-first pulse-distance bits, stop mark
// and guard gap, with a registered carrier-modulated LED drive.
module ir_encoder #(
    parameter int unsigned clk_hz     = 25000000,
    parameter int unsigned carrier_hz = 38000,
    parameter int unsigned gap_units  = 72
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        valid,
    input  logic [31:0] command,
    output logic        ready,
    output logic        done,
    output logic        envelope,
    output logic        ir_out
);

    localparam int unsigned UNIT_CYCLES  = 32'((64'(clk_hz) * 64'd5625) / 64'd10000000);
    localparam int unsigned CARRIER_HALF = clk_hz / (2 * carrier_hz);
    localparam int unsigned MAX_UNITS    = (gap_units > 16) ? gap_units : 16;
    localparam int unsigned CNT_W        = $clog2(MAX_UNITS * UNIT_CYCLES);
    localparam int unsigned CAR_W        = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         r_idx;
    logic [31:0]        r_cmd;
    logic               r_live;
    logic               r_done;
    logic               r_env;
    logic [CAR_W-1:0]   r_car_cnt;
    logic               r_car_ph;
    logic               r_ir;

    logic w_end;
    logic w_abort;
    logic w_accept;
    logic w_enter_mark;
    logic w_leave_mark;

    // The counter holds the remaining cycles of the current state minus one.
    function automatic logic [CNT_W-1:0] span(input int unsigned units);
        return CNT_W'(units * UNIT_CYCLES - 1);
    endfunction

    assign ready        = (r_state == S_IDLE) && enable && r_live;
    assign w_accept     = valid && ready;
    assign w_end        = (r_cnt == '0);
    assign w_abort      = !enable && (r_state inside {S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK,
                                                      S_BIT_SPACE, S_STOP_MARK});
    assign w_enter_mark = !w_abort && (w_accept ||
                          (w_end && (r_state == S_LEAD_SPACE || r_state == S_BIT_SPACE)));
    assign w_leave_mark = w_abort || (w_end && r_env);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_cmd     <= '0;
            r_live    <= 1'b0;
            r_done    <= 1'b0;
            r_env     <= 1'b0;
            r_car_cnt <= '0;
            r_car_ph  <= 1'b0;
            r_ir      <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= S_GAP;
                r_cnt   <= span(gap_units);
                r_env   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_cmd   <= command;
                            r_idx   <= '0;
                            r_state <= S_LEAD_MARK;
                            r_cnt   <= span(16);
                            r_env   <= 1'b1;
                        end
                    end
                    S_LEAD_MARK: begin
                        if (w_end) begin
                            r_state <= S_LEAD_SPACE;
                            r_cnt   <= span(8);
                            r_env   <= 1'b0;
                        end else r_cnt <= r_cnt - 1'b1;
                    end
                    S_LEAD_SPACE: begin
                        if (w_end) begin
                            r_state <= S_BIT_MARK;
                            r_cnt   <= span(1);
                            r_env   <= 1'b1;
                        end else r_cnt <= r_cnt - 1'b1;
                    end
                    S_BIT_MARK: begin
                        if (w_end) begin
                            r_state <= S_BIT_SPACE;
                            r_cnt   <= r_cmd[r_idx] ? span(3) : span(1);
                            r_env   <= 1'b0;
                        end else r_cnt <= r_cnt - 1'b1;
                    end
                    S_BIT_SPACE: begin
                        if (w_end && r_idx == 5'd31) begin
                            r_state <= S_STOP_MARK;
                            r_cnt   <= span(1);
                            r_env   <= 1'b1;
                            r_done  <= (span(1) == '0);
                        end else if (w_end) begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_BIT_MARK;
                            r_cnt   <= span(1);
                            r_env   <= 1'b1;
                        end else r_cnt <= r_cnt - 1'b1;
                    end
                    S_STOP_MARK: begin
                        if (w_end) begin
                            r_state <= S_GAP;
                            r_cnt   <= span(gap_units);
                            r_env   <= 1'b0;
                        end else begin
                            r_cnt  <= r_cnt - 1'b1;
                            r_done <= (r_cnt == CNT_W'(1));
                        end
                    end
                    S_GAP: begin
                        if (w_end) r_state <= S_IDLE;
                        else       r_cnt   <= r_cnt - 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            // NOTE: the carrier looks at next-cycle mark entry/exit so ir_out stays a flop yet lines up with envelope.
            if (w_enter_mark) begin
                r_car_cnt <= '0;
                r_car_ph  <= 1'b1;
                r_ir      <= 1'b1;
            end else if (r_env && !w_leave_mark) begin
                if (r_car_cnt == CAR_W'(CARRIER_HALF - 1)) begin
                    r_car_cnt <= '0;
                    r_car_ph  <= ~r_car_ph;
                    r_ir      <= ~r_car_ph;
                end else begin
                    r_car_cnt <= r_car_cnt + 1'b1;
                    r_ir      <= r_car_ph;
                end
            end else begin
                r_car_cnt <= '0;
                r_car_ph  <= 1'b0;
                r_ir      <= 1'b0;
            end
        end
    end

    assign done     = r_done;
    assign envelope = r_env;
    assign ir_out   = r_ir;

endmodule

// File: tb/tb_ir_encoder.sv
// Directed bench for ir_encoder: table of NEC frames plus hand-written
// reset, enable-abort and reset-mid-frame sequences at a scaled-down clock.
module tb_ir_encoder;

    localparam int unsigned CLK_HZ     = 35000;
    localparam int unsigned CARRIER_HZ = 3000;
    localparam int unsigned GAP_UNITS  = 72;
    localparam int U       = 19;    // 35000*5625/10000000 = 19.6875 -> 19
    localparam int HALF    = 5;     // 35000/6000 = 5.83 -> 5
    localparam int TIMEOUT = 8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        valid;
    logic [31:0] command;
    logic        ready;
    logic        done;
    logic        envelope;
    logic        ir_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] cmd;
        int          frame_units;
        int          first_space_units;
    } vec_t;

    vec_t vecs[5];

    ir_encoder #(
        .clk_hz     (CLK_HZ),
        .carrier_hz (CARRIER_HZ),
        .gap_units  (GAP_UNITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .valid    (valid),
        .command  (command),
        .ready    (ready),
        .done     (done),
        .envelope (envelope),
        .ir_out   (ir_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Waits (bounded) for ready, offers one command and returns on the first LEAD_MARK cycle.
    task automatic offer(input logic [31:0] cmd, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, 32'(ready), 1);
        command = cmd;
        valid   = 1'b1;
        @(negedge clk);
        valid   = 1'b0;
        command = ~cmd;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int exp_runs[67];
        int meas[67];
        int run_idx, run_len, run_err, car_err, frame_cyc, done_cnt, marks, gap, gap_err;
        logic level, exp_ir;
        bit got;
        string tag;
        tag = $sformatf("v%0d", idx);
        exp_runs[0] = 16 * U;
        exp_runs[1] = 8 * U;
        for (int b = 0; b < 32; b++) begin
            exp_runs[2 + 2 * b] = U;
            exp_runs[3 + 2 * b] = v.cmd[b] ? 3 * U : U;
        end
        exp_runs[66] = U;
        for (int i = 0; i < 67; i++) meas[i] = 0;
        run_idx = 0; run_len = 0; run_err = 0; car_err = 0;
        frame_cyc = 0; done_cnt = 0; marks = 1; gap = 0; gap_err = 0;
        level = 1'b1;
        got = 0;
        offer(v.cmd, tag);
        for (int c = 0; c < TIMEOUT && !got; c++) begin
            if (envelope !== level) begin
                if (run_idx < 67) begin
                    meas[run_idx] = run_len;
                    if (run_len != exp_runs[run_idx]) run_err++;
                end
                run_idx++;
                run_len = 0;
                level = envelope;
                if (envelope === 1'b1) marks++;
            end
            exp_ir = (envelope === 1'b1) && ((run_len / HALF) % 2 == 0);
            if (ir_out !== exp_ir) car_err++;
            run_len++;
            frame_cyc++;
            if (done === 1'b1) begin
                done_cnt++;
                if (run_idx < 67) begin
                    meas[run_idx] = run_len;
                    if (run_len != exp_runs[run_idx]) run_err++;
                end
                run_idx++;
                got = 1;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_frame_cycles"}, frame_cyc, v.frame_units * U);
        check({tag, "_run_count"}, run_idx, 67);
        check({tag, "_run_len_errors"}, run_err, 0);
        check({tag, "_marks"}, marks, 34);
        check({tag, "_first_space"}, meas[3], v.first_space_units * U);
        check({tag, "_carrier_errors"}, car_err, 0);
        @(negedge clk);
        while (ready !== 1'b1 && gap < TIMEOUT) begin
            if (envelope !== 1'b0 || ir_out !== 1'b0) gap_err++;
            if (done === 1'b1) done_cnt++;
            gap++;
            @(negedge clk);
        end
        check({tag, "_gap_cycles"}, gap, GAP_UNITS * U);
        check({tag, "_gap_quiet"}, gap_err, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs, gap, dn;

        vecs[0] = '{32'h00FF00FF, 121, 3};
        vecs[1] = '{32'h00000001,  91, 3};
        vecs[2] = '{32'h80000000,  91, 1};
        vecs[3] = '{32'hFFFFFFFF, 153, 3};
        vecs[4] = '{32'h00000000,  89, 1};

        // Reset with enable high: ready held low, outputs quiet, ready next cycle after release.
        rst = 1'b1; enable = 1'b1; valid = 1'b0; command = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 0);
        check("rst_envelope", 32'(envelope), 0);
        check("rst_ir_out", 32'(ir_out), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(ready), 1);

        // Disabled IDLE: ready low and a held valid is ignored.
        enable = 1'b0;
        valid  = 1'b1;
        command = 32'h12345678;
        errs = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready !== 1'b0 || envelope !== 1'b0) errs++;
        end
        check("disabled_idle_quiet", errs, 0);
        valid  = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check("reenable_ready", 32'(ready), 1);

        for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

        // Enable dropped in bit 10's space of 0x00FF00FF: 24U leader + 8*4U + 2*2U + 1U mark.
        offer(32'h00FF00FF, "abort");
        for (int n = 0; n < 61 * U + 2; n++) @(negedge clk);
        check("abort_in_space_env", 32'(envelope), 0);
        enable  = 1'b0;
        valid   = 1'b1;
        command = 32'hDEADBEEF;
        @(negedge clk);
        check("abort_env_next", 32'(envelope), 0);
        gap = 0; errs = 0; dn = 0;
        while (ready !== 1'b1 && gap < TIMEOUT) begin
            if (envelope !== 1'b0 || ir_out !== 1'b0) errs++;
            if (done === 1'b1) dn++;
            gap++;
            if (gap == 40 * U) enable = 1'b1;
            @(negedge clk);
        end
        valid = 1'b0;
        check("abort_gap_cycles", gap, GAP_UNITS * U);
        check("abort_gap_quiet", errs, 0);
        check("abort_no_done", dn, 0);
        @(negedge clk);
        check("abort_not_queued", 32'(envelope), 0);

        // Reset during LEAD_MARK: output drops next cycle, no gap afterwards.
        offer(32'hA5A50F0F, "rst_mid");
        repeat (3) @(negedge clk);
        check("lead_ir_high", 32'(ir_out), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ir_out", 32'(ir_out), 0);
        check("mid_rst_envelope", 32'(envelope), 0);
        check("mid_rst_ready", 32'(ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_after", 32'(ready), 1);
        errs = 0;
        repeat (30 * U) begin
            @(negedge clk);
            if (envelope !== 1'b0 || done !== 1'b0 || ready !== 1'b1) errs++;
        end
        check("mid_rst_stays_idle", errs, 0);

        run_frame(vecs[0], 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
